// File: rtl/muldiv_div_ctrl.sv
// muldiv_div_ctrl: control stage in front of the 32-bit unsigned restoring divider core.
// Accepts RV32M DIV/DIVU/REM/REMU requests, converts signed operands to magnitudes, runs the
// core through its start/busy handshake, sign-corrects the core's quotient/remainder and
// returns one 32-bit result. Divide-by-zero is answered without the core; a one-entry cache
// of the last completed division lets a DIV/REM pair on the same operands cost one division.
//
// Ports:
//   clk, rst               clock; synchronous active-high reset
//   req_valid/req_ready    request handshake (ready only in IDLE)
//   req_op                 funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   req_rs1, req_rs2       dividend, divisor
//   res_valid, res_data    one-cycle result pulse and data
//   div_a, div_b           registered unsigned operands to the core
//   div_start              registered one-cycle start pulse to the core
//   div_q, div_r, div_busy core quotient, remainder and busy flag
module muldiv_div_ctrl #(
  parameter bit CACHE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_start,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  input  logic        div_busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e state_q;

  // Request decode
  logic        req_signed;
  logic        req_rem;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        req_q_neg;
  logic        req_r_neg;
  logic        cache_hit;

  // Operation in flight
  logic [31:0] op_rs1_q;
  logic [31:0] op_rs2_q;
  logic        op_signed_q;
  logic        op_rem_q;
  logic        op_q_neg_q;
  logic        op_r_neg_q;

  // Last-result cache
  logic        cache_vld_q;
  logic [31:0] cache_rs1_q;
  logic [31:0] cache_rs2_q;
  logic        cache_signed_q;
  logic [31:0] cache_q_q;
  logic [31:0] cache_r_q;

  // Sign-corrected core outputs
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  assign req_ready = (state_q == StIdle);

  always_comb begin
    req_signed = ~req_op[0];
    req_rem    = req_op[1];
    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    a_mag      = (req_signed && req_rs1[31]) ? (~req_rs1 + 32'd1) : req_rs1;
    b_mag      = (req_signed && req_rs2[31]) ? (~req_rs2 + 32'd1) : req_rs2;
    req_q_neg  = req_signed & (req_rs1[31] ^ req_rs2[31]);
    req_r_neg  = req_signed & req_rs1[31];
    cache_hit  = CACHE_EN && cache_vld_q && (req_rs1 == cache_rs1_q) &&
                 (req_rs2 == cache_rs2_q) && (req_signed == cache_signed_q);
    q_fix      = op_q_neg_q ? (~div_q + 32'd1) : div_q;
    r_fix      = op_r_neg_q ? (~div_r + 32'd1) : div_r;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      res_valid      <= 1'b0;
      res_data       <= 32'd0;
      div_start      <= 1'b0;
      div_a          <= 32'd0;
      div_b          <= 32'd0;
      op_rs1_q       <= 32'd0;
      op_rs2_q       <= 32'd0;
      op_signed_q    <= 1'b0;
      op_rem_q       <= 1'b0;
      op_q_neg_q     <= 1'b0;
      op_r_neg_q     <= 1'b0;
      cache_vld_q    <= 1'b0;
      cache_rs1_q    <= 32'd0;
      cache_rs2_q    <= 32'd0;
      cache_signed_q <= 1'b0;
      cache_q_q      <= 32'd0;
      cache_r_q      <= 32'd0;
    end else begin
      res_valid <= 1'b0;
      div_start <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            if (req_rs2 == 32'd0) begin
              // RISC-V divide-by-zero: quotient all ones, remainder is the dividend.
              res_data  <= req_rem ? req_rs1 : 32'hFFFF_FFFF;
              res_valid <= 1'b1;
              state_q   <= StDone;
            end else if (cache_hit) begin
              res_data  <= req_rem ? cache_r_q : cache_q_q;
              res_valid <= 1'b1;
              state_q   <= StDone;
            end else begin
              div_a       <= a_mag;
              div_b       <= b_mag;
              op_rs1_q    <= req_rs1;
              op_rs2_q    <= req_rs2;
              op_signed_q <= req_signed;
              op_rem_q    <= req_rem;
              op_q_neg_q  <= req_q_neg;
              op_r_neg_q  <= req_r_neg;
              // Registered so the pulse lines up with the ISSUE cycle.
              div_start   <= 1'b1;
              state_q     <= StIssue;
            end
          end
        end
        StIssue: begin
          state_q <= StWait;
        end
        StWait: begin
          // The core raises busy the cycle after start, or never when a < b.
          if (!div_busy) begin
            res_data       <= op_rem_q ? r_fix : q_fix;
            res_valid      <= 1'b1;
            cache_vld_q    <= 1'b1;
            cache_rs1_q    <= op_rs1_q;
            cache_rs2_q    <= op_rs2_q;
            cache_signed_q <= op_signed_q;
            cache_q_q      <= q_fix;
            cache_r_q      <= r_fix;
            state_q        <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_div_ctrl.sv
// tb_muldiv_div_ctrl: self-checking bench for muldiv_div_ctrl. Contains a behavioural model
// of the restoring divider core (busy for a fixed number of cycles when a >= b, combinational
// q=0/r=a when a < b), a table of request vectors with expected data and latency, a
// scoreboard queue of expected results, and hand sequences for mid-operation reset and
// back-to-back requests.
module tb_muldiv_div_ctrl;

  localparam int BUSY = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic        res_valid;
  logic [31:0] res_data;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_start;
  logic [31:0] div_q;
  logic [31:0] div_r;
  logic        div_busy;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int busy_cnt = 0;

  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  muldiv_div_ctrl #(.CACHE_EN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_rs1   (req_rs1),
    .req_rs2   (req_rs2),
    .res_valid (res_valid),
    .res_data  (res_data),
    .div_a     (div_a),
    .div_b     (div_b),
    .div_start (div_start),
    .div_q     (div_q),
    .div_r     (div_r),
    .div_busy  (div_busy)
  );

  // Divider core model; reset together with the control stage.
  logic        core_busy;
  logic [31:0] core_q;
  logic [31:0] core_r;
  int          core_cnt;

  always @(posedge clk) begin
    if (rst) begin
      core_busy <= 1'b0;
      core_cnt  <= 0;
      core_q    <= 32'd0;
      core_r    <= 32'd0;
    end else if (div_start && !core_busy) begin
      core_q <= 32'hDEAD_BEEF;
      core_r <= 32'hDEAD_BEEF;
      if (div_a >= div_b) begin
        core_busy <= 1'b1;
        core_cnt  <= BUSY;
      end
    end else if (core_busy) begin
      if (core_cnt == 1) begin
        core_busy <= 1'b0;
        core_q    <= div_a / div_b;
        core_r    <= div_a % div_b;
      end
      core_cnt <= core_cnt - 1;
    end
  end

  assign div_busy = core_busy;
  assign div_q    = (div_a < div_b) ? 32'd0 : core_q;
  assign div_r    = (div_a < div_b) ? div_a : core_r;

  always @(posedge clk) begin
    if (div_start) start_cnt <= start_cnt + 1;
    if (div_busy) busy_cnt <= busy_cnt + 1;
  end

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic sgn;
    logic rem;
    sgn = ~op[0];
    rem = op[1];
    if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'd0 : 32'h8000_0000;
    if (sgn) return rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return rem ? (a % b) : (a / b);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Called at #1 after an edge while the DUT is idle; returns #1 after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] want);
    int guard;
    guard     = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_rs1   = a;
    req_rs2   = b;
    while (!req_ready && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL send: req_ready stuck low got 0 want 1");
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    exp_q.push_back(want);
  endtask

  task automatic wait_result(input string name, input int exp_lat);
    int          lat;
    logic [31:0] want;
    lat = 1;
    while (!res_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!res_valid) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: res_valid got 0 want 1 within %0d cycles", name, lat);
      exp_q.delete();
    end else if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: unexpected res_valid got 1 want 0", name);
    end else begin
      want = exp_q.pop_front();
      check({name, " data"}, res_data, want);
      if (exp_lat > 0) check({name, " latency"}, 32'(lat), 32'(exp_lat));
      @(posedge clk);
      #1;
      check({name, " pulse"}, {31'd0, res_valid}, 32'd0);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] want;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int          s0;
    int          b0;
    int          lat;
    int          nvalid;
    logic [1:0]  op;
    logic [1:0]  prev_op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] prev_a;
    logic [31:0] prev_b;
    logic [31:0] want;

    // op: 00 DIV, 01 DIVU, 10 REM, 11 REMU
    vecs[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         3 + BUSY};
    vecs[1]  = '{2'b11, 32'd100,        32'd7,          32'd2,          1};
    vecs[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  3 + BUSY};
    vecs[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1};
    vecs[4]  = '{2'b01, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  3 + BUSY};
    vecs[5]  = '{2'b00, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  1};
    vecs[6]  = '{2'b10, 32'h1234_5678,  32'd0,          32'h1234_5678,  1};
    vecs[7]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  3 + BUSY};
    vecs[8]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
    vecs[9]  = '{2'b11, 32'd5,          32'd9,          32'd5,          3};
    vecs[10] = '{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  3 + BUSY};
    vecs[11] = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          1};
    vecs[12] = '{2'b00, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          3 + BUSY};
    vecs[13] = '{2'b10, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'hFFFF_FFFF,  1};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_rs1   = 32'd0;
    req_rs2   = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset req_ready", {31'd0, req_ready}, 32'd1);
    check("reset res_valid", {31'd0, res_valid}, 32'd0);
    check("reset res_data", res_data, 32'd0);
    check("reset div_start", {31'd0, div_start}, 32'd0);
    check("reset div_a", div_a, 32'd0);
    check("reset div_b", div_b, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      s0 = start_cnt;
      b0 = busy_cnt;
      send(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].want);
      wait_result($sformatf("vec%0d", i), vecs[i].lat);
      check($sformatf("vec%0d starts", i), 32'(start_cnt - s0), (vecs[i].lat == 1) ? 32'd0 : 32'd1);
      check($sformatf("vec%0d busy cycles", i), 32'(busy_cnt - b0),
            (vecs[i].lat == 3 + BUSY) ? 32'(BUSY) : 32'd0);
    end

    // Reset during WAIT: no result, back to IDLE, cache emptied.
    send(2'b01, 32'd100, 32'd7, 32'd14);
    wait_result("pre-reset fill", 3 + BUSY);
    send(2'b01, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    check("post-reset req_ready", {31'd0, req_ready}, 32'd1);
    nvalid = 0;
    for (int c = 0; c < 12; c++) begin
      if (res_valid) nvalid++;
      @(posedge clk);
      #1;
    end
    check("post-reset res_valid count", 32'(nvalid), 32'd0);
    send(2'b11, 32'd100, 32'd7, 32'd2);
    wait_result("post-reset cache miss", 3 + BUSY);
    send(2'b01, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555);
    wait_result("post-reset repeat", 3 + BUSY);

    // Back-to-back with req_valid held high; second op reuses operands to exercise the cache.
    prev_op   = 2'b00;
    prev_a    = 32'd0;
    prev_b    = 32'd0;
    req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      if (k == 1) begin
        op = prev_op ^ 2'b10;
        a  = prev_a;
        b  = prev_b;
      end
      req_op  = op;
      req_rs1 = a;
      req_rs2 = b;
      check($sformatf("b2b%0d ready before accept", k), {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      #1;
      exp_q.push_back(ref_div(op, a, b));
      lat = 1;
      while (!res_valid && lat < 60) begin
        check($sformatf("b2b%0d ready busy", k), {31'd0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        lat++;
      end
      if (!res_valid) begin
        checks++;
        errors++;
        $display("FAIL b2b%0d timeout: res_valid got 0 want 1", k);
        exp_q.delete();
      end else begin
        check($sformatf("b2b%0d ready in done", k), {31'd0, req_ready}, 32'd0);
        want = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
        check($sformatf("b2b%0d data", k), res_data, want);
      end
      @(posedge clk);
      #1;
      prev_op = op;
      prev_a  = a;
      prev_b  = b;
    end
    req_valid = 1'b0;
    check("b2b ready after last", {31'd0, req_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
